// File: rtl/stream_arb_pkg.sv
// Shared FSM encoding, default widths and clog2 helper for the stream sink arbiter.
package stream_arb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ID_W_DEF   = 2;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    SEND   = 2'd2
  } arb_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) result = result + 1;
    return result;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority pick: first asserted request at or after ptr, wrapping modulo N_CH.
module rr_priority_pick
  import stream_arb_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned ID_W = ID_W_DEF
) (
  input  logic [N_CH-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] gnt_idx,
  output logic            gnt_valid
);

  // rot_idx + ptr is below 2*N_CH, so one extra bit covers the un-rotate sum
  localparam int unsigned SUM_W = clog2(2 * N_CH);

  logic [N_CH-1:0]  req_rot;
  logic [ID_W-1:0]  rot_idx;
  logic [SUM_W-1:0] idx_sum;

  always_comb begin
    req_rot = '0;
    for (int i = 0; i < N_CH; i++) begin
      req_rot[i] = req[(i + int'(ptr)) % N_CH];
    end
    rot_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_rot[i]) rot_idx = ID_W'(i);
    end
    idx_sum   = SUM_W'(rot_idx) + SUM_W'(ptr);
    gnt_idx   = (idx_sum >= SUM_W'(N_CH)) ? ID_W'(idx_sum - SUM_W'(N_CH)) : ID_W'(idx_sum);
    gnt_valid = |req;
  end

endmodule

// File: rtl/stream_sink_arbiter.sv
// Round-robin arbiter sharing one 32-bit stb/ack sample sink among N_CH producer streams.
// Define STREAM_ARB_SAMPLE_COUNT_EN to add per-channel completed-sample counters (sample_cnt).
module stream_sink_arbiter
  import stream_arb_pkg::*;
#(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ID_W   = ID_W_DEF
`ifdef STREAM_ARB_SAMPLE_COUNT_EN
  ,
  parameter int unsigned CNT_W  = CNT_W_DEF
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_stb,
  output logic [N_CH-1:0]        in_ack,
  output logic [DATA_W-1:0]      out_data,
  output logic [ID_W-1:0]        out_id,
  output logic                   out_stb,
  input  logic                   out_ack,
  output logic                   busy
`ifdef STREAM_ARB_SAMPLE_COUNT_EN
  ,
  output logic [N_CH*CNT_W-1:0]  sample_cnt
`endif
);

  arb_state_e        state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   grant_next;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_valid;
  logic [DATA_W-1:0] ch_data [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_ch_data
    assign ch_data[k] = in_data[k*DATA_W +: DATA_W];
  end

  rr_priority_pick #(
    .N_CH (N_CH),
    .ID_W (ID_W)
  ) u_pick (
    .req       (in_stb),
    .ptr       (rr_ptr),
    .gnt_idx   (pick_idx),
    .gnt_valid (pick_valid)
  );

  assign grant_next = (grant == ID_W'(N_CH - 1)) ? '0 : grant + ID_W'(1);

  // Grant / capture / present: one sample in flight, en only gates new grants
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      in_ack   <= '0;
      out_data <= '0;
      out_id   <= '0;
      out_stb  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en && pick_valid) begin
            grant  <= pick_idx;
            in_ack <= N_CH'(1) << pick_idx;
            busy   <= 1'b1;
            state  <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (in_stb[grant]) begin
            out_data <= ch_data[grant];
            out_id   <= grant;
            in_ack   <= '0;
            out_stb  <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (out_ack) begin
            out_stb <= 1'b0;
            rr_ptr  <= grant_next;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          in_ack  <= '0;
          out_stb <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef STREAM_ARB_SAMPLE_COUNT_EN
  logic [CNT_W-1:0] cnt_q [N_CH];

  // Counts completed downstream transfers per channel, wrapping naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N_CH; k++) cnt_q[k] <= '0;
    end else if (state == SEND && out_ack) begin
      cnt_q[out_id] <= cnt_q[out_id] + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_cnt_out
    assign sample_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
  end
`endif

endmodule
